// File: rtl/rs_cdb_wakeup.sv
// Reservation station with dual-CDB wakeup, oldest-ready select and branch-mask squash.
// An age matrix orders entries; older_q[i][j] set means entry j was allocated before i.
module rs_cdb_wakeup #(
    parameter int DEPTH     = 8,
    parameter int PADDR_W   = 6,
    parameter int ROB_W     = 5,
    parameter int BMASK_W   = 4,
    parameter int PAYLOAD_W = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [PADDR_W-1:0]       alloc_ps1,
    input  logic [PADDR_W-1:0]       alloc_ps2,
    input  logic                     alloc_ps1_rdy,
    input  logic                     alloc_ps2_rdy,
    input  logic [PADDR_W-1:0]       alloc_pd,
    input  logic [ROB_W-1:0]         alloc_rob_idx,
    input  logic [BMASK_W-1:0]       alloc_bmask,
    input  logic [PAYLOAD_W-1:0]     alloc_payload,
    input  logic                     cdb0_valid,
    input  logic [PADDR_W-1:0]       cdb0_paddr,
    input  logic                     cdb1_valid,
    input  logic [PADDR_W-1:0]       cdb1_paddr,
    input  logic                     br_resolve_valid,
    input  logic [BMASK_W-1:0]       br_resolve_bit,
    input  logic                     br_mispred,
    output logic                     issue_valid,
    input  logic                     issue_stall,
    output logic [PADDR_W-1:0]       issue_ps1,
    output logic [PADDR_W-1:0]       issue_ps2,
    output logic [PADDR_W-1:0]       issue_pd,
    output logic [ROB_W-1:0]         issue_rob_idx,
    output logic [BMASK_W-1:0]       issue_bmask,
    output logic [PAYLOAD_W-1:0]     issue_payload,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     rdy1_q;
    logic [DEPTH-1:0]     rdy2_q;
    logic [PADDR_W-1:0]   ps1_q     [DEPTH];
    logic [PADDR_W-1:0]   ps2_q     [DEPTH];
    logic [PADDR_W-1:0]   pd_q      [DEPTH];
    logic [ROB_W-1:0]     rob_q     [DEPTH];
    logic [BMASK_W-1:0]   bmask_q   [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [DEPTH-1:0]     older_q   [DEPTH];

    logic [DEPTH-1:0] req;
    logic [DEPTH-1:0] sel_oh;
    logic [DEPTH-1:0] squash;
    logic [DEPTH-1:0] valid_d;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] free_idx;
    logic             sel_any;
    logic             sel_hit;
    logic             mis;
    logic             clr;
    logic             deq;
    logic             alloc_fire;
    logic [BMASK_W-1:0] alloc_bmask_eff;

    function automatic logic wake(input logic [PADDR_W-1:0] t);
        return (t == '0)
            || (cdb0_valid && (cdb0_paddr == t))
            || (cdb1_valid && (cdb1_paddr == t));
    endfunction

    assign mis = br_resolve_valid && br_mispred;
    assign clr = br_resolve_valid && !br_mispred;
    assign req = valid_q & rdy1_q & rdy2_q;

    always_comb begin
        sel_oh    = '0;
        sel_idx   = '0;
        free_idx  = '0;
        occupancy = '0;
        squash    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            sel_oh[i] = req[i] && ((older_q[i] & req) == '0);
            if (sel_oh[i])
                sel_idx = IDX_W'(i);
            if (!valid_q[i])
                free_idx = IDX_W'(i);
            squash[i] = mis && ((bmask_q[i] & br_resolve_bit) != '0);
            occupancy = occupancy + CNT_W'(valid_q[i]);
        end
    end

    assign sel_any     = |req;
    assign sel_hit     = squash[sel_idx];
    assign issue_valid = sel_any && !sel_hit;
    assign deq         = issue_valid && !issue_stall;
    assign alloc_ready = occupancy < CNT_W'(DEPTH);

    // A mispredict that hits the incoming op drops it before it lands
    assign alloc_fire = alloc_valid && alloc_ready
        && !(mis && ((alloc_bmask & br_resolve_bit) != '0));
    assign alloc_bmask_eff = clr ? (alloc_bmask & ~br_resolve_bit)
                                 : alloc_bmask;

    assign issue_ps1     = ps1_q[sel_idx];
    assign issue_ps2     = ps2_q[sel_idx];
    assign issue_pd      = pd_q[sel_idx];
    assign issue_rob_idx = rob_q[sel_idx];
    assign issue_bmask   = bmask_q[sel_idx];
    assign issue_payload = payload_q[sel_idx];

    always_comb begin
        valid_d = valid_q & ~squash;
        if (deq)
            valid_d[sel_idx] = 1'b0;
        if (alloc_fire)
            valid_d[free_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid_q <= '0;
        else
            valid_q <= valid_d;
    end

    // Payload state needs no reset; valid_q alone qualifies it
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_fire && (free_idx == IDX_W'(i))) begin
                ps1_q[i]     <= alloc_ps1;
                ps2_q[i]     <= alloc_ps2;
                pd_q[i]      <= alloc_pd;
                rob_q[i]     <= alloc_rob_idx;
                payload_q[i] <= alloc_payload;
                bmask_q[i]   <= alloc_bmask_eff;
                rdy1_q[i]    <= alloc_ps1_rdy || wake(alloc_ps1);
                rdy2_q[i]    <= alloc_ps2_rdy || wake(alloc_ps2);
                older_q[i]   <= valid_q;
            end else begin
                rdy1_q[i] <= rdy1_q[i] || wake(ps1_q[i]);
                rdy2_q[i] <= rdy2_q[i] || wake(ps2_q[i]);
                if (clr)
                    bmask_q[i] <= bmask_q[i] & ~br_resolve_bit;
                if (alloc_fire)
                    older_q[i][free_idx] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs_cdb_wakeup.sv
// Directed bench for rs_cdb_wakeup: expected issues go to a scoreboard queue,
// a negedge monitor pops and compares every dequeue the DUT performs.
module tb_rs_cdb_wakeup;

    logic        clk;
    logic        rst_n;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [5:0]  alloc_ps1;
    logic [5:0]  alloc_ps2;
    logic        alloc_ps1_rdy;
    logic        alloc_ps2_rdy;
    logic [5:0]  alloc_pd;
    logic [4:0]  alloc_rob_idx;
    logic [3:0]  alloc_bmask;
    logic [63:0] alloc_payload;
    logic        cdb0_valid;
    logic [5:0]  cdb0_paddr;
    logic        cdb1_valid;
    logic [5:0]  cdb1_paddr;
    logic        br_resolve_valid;
    logic [3:0]  br_resolve_bit;
    logic        br_mispred;
    logic        issue_valid;
    logic        issue_stall;
    logic [5:0]  issue_ps1;
    logic [5:0]  issue_ps2;
    logic [5:0]  issue_pd;
    logic [4:0]  issue_rob_idx;
    logic [3:0]  issue_bmask;
    logic [63:0] issue_payload;
    logic [3:0]  occupancy;

    typedef struct {
        logic [4:0]  rob;
        logic [5:0]  ps2;
        logic [3:0]  bm;
        logic [63:0] pl;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    rs_cdb_wakeup dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_ps1(alloc_ps1), .alloc_ps2(alloc_ps2),
        .alloc_ps1_rdy(alloc_ps1_rdy), .alloc_ps2_rdy(alloc_ps2_rdy),
        .alloc_pd(alloc_pd), .alloc_rob_idx(alloc_rob_idx),
        .alloc_bmask(alloc_bmask), .alloc_payload(alloc_payload),
        .cdb0_valid(cdb0_valid), .cdb0_paddr(cdb0_paddr),
        .cdb1_valid(cdb1_valid), .cdb1_paddr(cdb1_paddr),
        .br_resolve_valid(br_resolve_valid),
        .br_resolve_bit(br_resolve_bit), .br_mispred(br_mispred),
        .issue_valid(issue_valid), .issue_stall(issue_stall),
        .issue_ps1(issue_ps1), .issue_ps2(issue_ps2),
        .issue_pd(issue_pd), .issue_rob_idx(issue_rob_idx),
        .issue_bmask(issue_bmask), .issue_payload(issue_payload),
        .occupancy(occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] pl_of(input logic [4:0] rob);
        return 64'hC0DE_0000_0000_0000 | 64'(rob);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && issue_valid && !issue_stall) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_issue: got rob %0d expected none",
                         issue_rob_idx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("issue_rob", 64'(issue_rob_idx), 64'(e.rob));
                chk("issue_ps2", 64'(issue_ps2), 64'(e.ps2));
                chk("issue_bmask", 64'(issue_bmask), 64'(e.bm));
                chk("issue_payload", issue_payload, e.pl);
            end
        end
    end

    task automatic idle_inputs();
        alloc_valid = 0; alloc_ps1 = 0; alloc_ps2 = 0;
        alloc_ps1_rdy = 0; alloc_ps2_rdy = 0; alloc_pd = 0;
        alloc_rob_idx = 0; alloc_bmask = 0; alloc_payload = 0;
        cdb0_valid = 0; cdb0_paddr = 0; cdb1_valid = 0; cdb1_paddr = 0;
        br_resolve_valid = 0; br_resolve_bit = 0; br_mispred = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        issue_stall = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
    endtask

    task automatic alloc_set(input logic [4:0] rob,
                             input logic [5:0] ps1, input logic r1,
                             input logic [5:0] ps2, input logic r2,
                             input logic [3:0] bm);
        alloc_valid = 1; alloc_rob_idx = rob;
        alloc_ps1 = ps1; alloc_ps1_rdy = r1;
        alloc_ps2 = ps2; alloc_ps2_rdy = r2;
        alloc_pd = 6'(rob) + 6'd32; alloc_bmask = bm;
        alloc_payload = pl_of(rob);
    endtask

    task automatic push(input logic [4:0] rob, input logic [5:0] ps2,
                        input logic [3:0] bm);
        exp_t e;
        e.rob = rob; e.ps2 = ps2; e.bm = bm; e.pl = pl_of(rob);
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 40 && sb.size() != 0; n++)
            tick();
        chk(name, 64'(sb.size()), 64'd0);
        tick();
        chk({name, "_occ"}, 64'(occupancy), 64'd0);
    endtask

    initial begin
        rst_n = 0;
        issue_stall = 0;
        idle_inputs();

        // Wakeup on cdb1 three cycles after allocation
        do_reset();
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_ready", 64'(alloc_ready), 64'd1);
        chk("rst_issue", 64'(issue_valid), 64'd0);
        alloc_set(5'd1, 6'd5, 1'b1, 6'd7, 1'b0, 4'b0000);
        push(5'd1, 6'd7, 4'b0000);
        tick();
        chk("t1_occ1", 64'(occupancy), 64'd1);
        chk("t1_wait", 64'(issue_valid), 64'd0);
        tick();
        tick();
        cdb1_valid = 1; cdb1_paddr = 6'd7;
        #1 chk("t1_same_cycle", 64'(issue_valid), 64'd0);
        tick();
        chk("t1_woken", 64'(issue_valid), 64'd1);
        chk("t1_occ_pre", 64'(occupancy), 64'd1);
        tick();
        chk("t1_occ_post", 64'(occupancy), 64'd0);
        chk("t1_idle", 64'(issue_valid), 64'd0);

        // Fill under stall, then release; tag 0 counts as ready
        do_reset();
        issue_stall = 1;
        for (int k = 0; k < 8; k++) begin
            alloc_set(5'(k), 6'd1, 1'b1, 6'd0, 1'b0, 4'b0000);
            push(5'(k), 6'd0, 4'b0000);
            tick();
        end
        chk("t2_full_occ", 64'(occupancy), 64'd8);
        chk("t2_full_ready", 64'(alloc_ready), 64'd0);
        alloc_set(5'd8, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0000);
        tick();
        chk("t2_full_reject", 64'(occupancy), 64'd8);
        issue_stall = 0;
        alloc_set(5'd8, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0000);
        tick();
        chk("t2_full_issue", 64'(occupancy), 64'd7);
        alloc_set(5'd8, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0000);
        push(5'd8, 6'd2, 4'b0000);
        tick();
        chk("t2_refill", 64'(occupancy), 64'd7);
        drain("t2_drain");

        // Allocation bypass from cdb0
        do_reset();
        alloc_set(5'd9, 6'd9, 1'b0, 6'd0, 1'b0, 4'b0000);
        cdb0_valid = 1; cdb0_paddr = 6'd9;
        push(5'd9, 6'd0, 4'b0000);
        tick();
        chk("t3_bypass", 64'(issue_valid), 64'd1);
        drain("t3_drain");

        // Mispredict squash, then correct resolve clears the mask bit
        do_reset();
        issue_stall = 1;
        alloc_set(5'd1, 6'd1, 1'b1, 6'd1, 1'b1, 4'b0001);
        tick();
        alloc_set(5'd2, 6'd1, 1'b1, 6'd1, 1'b1, 4'b0010);
        tick();
        alloc_set(5'd3, 6'd1, 1'b1, 6'd1, 1'b1, 4'b0011);
        tick();
        chk("t4_occ3", 64'(occupancy), 64'd3);
        chk("t4_sel_before", 64'(issue_rob_idx), 64'd1);
        br_resolve_valid = 1; br_resolve_bit = 4'b0001; br_mispred = 1;
        alloc_set(5'd4, 6'd1, 1'b1, 6'd1, 1'b1, 4'b0101);
        #1 chk("t4_squash_comb", 64'(issue_valid), 64'd0);
        tick();
        chk("t4_occ1", 64'(occupancy), 64'd1);
        br_resolve_valid = 1; br_resolve_bit = 4'b0010; br_mispred = 0;
        alloc_set(5'd5, 6'd1, 1'b1, 6'd1, 1'b1, 4'b0010);
        push(5'd2, 6'd1, 4'b0000);
        push(5'd5, 6'd1, 4'b0000);
        tick();
        chk("t4_occ2", 64'(occupancy), 64'd2);
        chk("t4_bmask_clr", 64'(issue_bmask), 64'd0);
        issue_stall = 0;
        drain("t4_drain");

        // Simultaneous wakeup from both CDB ports
        do_reset();
        alloc_set(5'd6, 6'd3, 1'b0, 6'd4, 1'b0, 4'b0000);
        push(5'd6, 6'd4, 4'b0000);
        tick();
        chk("t5_wait", 64'(issue_valid), 64'd0);
        cdb0_valid = 1; cdb0_paddr = 6'd3;
        cdb1_valid = 1; cdb1_paddr = 6'd4;
        tick();
        chk("t5_woken", 64'(issue_valid), 64'd1);
        drain("t5_drain");

        // Asynchronous reset with a stalled, partly full station
        do_reset();
        issue_stall = 1;
        for (int k = 0; k < 5; k++) begin
            alloc_set(5'(k + 10), 6'd1, 1'b1, 6'd1, 1'b1, 4'b0000);
            tick();
        end
        chk("t6_occ5", 64'(occupancy), 64'd5);
        #2 rst_n = 0;
        #1;
        chk("t6_async_occ", 64'(occupancy), 64'd0);
        chk("t6_async_issue", 64'(issue_valid), 64'd0);
        chk("t6_async_ready", 64'(alloc_ready), 64'd1);
        @(posedge clk);
        #2 rst_n = 1;
        issue_stall = 0;
        tick();
        chk("t6_after", 64'(issue_valid), 64'd0);
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
